// File: rtl/i2c_cfg_sequencer_if.sv
// Bus between the codec configuration sequencer (master) and its surroundings:
// the 24-bit I2C write engine plus the runtime user write/status handshake.
interface i2c_cfg_sequencer_if;
  logic        I2C_CTRL_CLK;
  logic [23:0] I2C_DATA;
  logic        GO;
  logic        W_R;
  logic        END;
  logic        ACK;
  logic        MUTE;
  logic        USR_REQ;
  logic [15:0] USR_WORD;
  logic        USR_DONE;
  logic        USR_ERR;
  logic        CFG_DONE;
  logic        CFG_ERR;
  logic [3:0]  CFG_INDEX;
  logic        BUSY;

  modport master (
    output I2C_CTRL_CLK, I2C_DATA, GO, W_R,
    output USR_DONE, USR_ERR, CFG_DONE, CFG_ERR, CFG_INDEX, BUSY,
    input  END, ACK, MUTE, USR_REQ, USR_WORD
  );

  modport slave (
    input  I2C_CTRL_CLK, I2C_DATA, GO, W_R,
    input  USR_DONE, USR_ERR, CFG_DONE, CFG_ERR, CFG_INDEX, BUSY,
    output END, ACK, MUTE, USR_REQ, USR_WORD
  );
endinterface

// File: rtl/i2c_cfg_sequencer.sv
// Audio codec configuration sequencer: walks the init table through the I2C write
// engine after reset, with retry/timeout handling, then serves runtime user writes.
module i2c_cfg_sequencer #(
  parameter int         CLK_DIV     = 500,
  parameter logic [7:0] SLAVE_ADDR  = 8'h34,
  parameter int         NUM_REGS    = 11,
  parameter int         MAX_RETRY   = 3,
  parameter int         PWRUP_TICKS = 1024,
  parameter int         XFER_TMO    = 64
) (
  input  logic               CLOCK,
  input  logic               RESET,
  i2c_cfg_sequencer_if.master bus
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int PW = $clog2(PWRUP_TICKS + 1);
  localparam int TW = $clog2(XFER_TMO + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PWRUP_LAST = PW'(PWRUP_TICKS - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(XFER_TMO - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);
  localparam logic [3:0]    IDX_LAST   = 4'(NUM_REGS - 1);

  localparam logic [2:0] S_PWRUP = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_XFER  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_IDLE  = 3'd4;

  // NOTE: the init table is a constant ROM decoded from the index, so it has no
  // storage of its own and needs no reset.
  function automatic logic [15:0] table_word(input logic [3:0] idx);
    case (idx)
      4'd0:    return 16'h1E00;
      4'd1:    return 16'h001A;
      4'd2:    return 16'h021A;
      4'd3:    return 16'h047B;
      4'd4:    return 16'h067B;
      4'd5:    return 16'h08F8;
      4'd6:    return 16'h0A06;
      4'd7:    return 16'h0C00;
      4'd8:    return 16'h0E01;
      4'd9:    return 16'h1002;
      4'd10:   return 16'h1201;
      default: return 16'h0000;
    endcase
  endfunction

  logic [DW-1:0] div_cnt;
  logic          ctrl_clk;
  logic          tick;

  // The FSM stays on CLOCK and uses the 1->0 edge of the engine clock as an
  // enable, giving the engine half a period of setup before its rising edge.
  assign tick = (div_cnt == DIV_LAST) && ctrl_clk;

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      div_cnt  <= '0;
      ctrl_clk <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt  <= '0;
      ctrl_clk <= ~ctrl_clk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  logic [2:0]    state;
  logic [PW-1:0] pwr_cnt;
  logic          setup_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [RW-1:0] retry;
  logic          fail;
  logic          src_user;
  logic [23:0]   i2c_data;
  logic          go;
  logic          w_r;
  logic          usr_done;
  logic          usr_err;
  logic          cfg_done;
  logic          cfg_err;
  logic [3:0]    cfg_index;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state     <= S_PWRUP;
      pwr_cnt   <= '0;
      setup_cnt <= 1'b0;
      tmo_cnt   <= '0;
      retry     <= '0;
      fail      <= 1'b0;
      src_user  <= 1'b0;
      i2c_data  <= '0;
      go        <= 1'b0;
      w_r       <= 1'b0;
      usr_done  <= 1'b0;
      usr_err   <= 1'b0;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
      cfg_index <= '0;
    end else begin
      usr_done <= 1'b0;
      if (tick) begin
        case (state)
          S_PWRUP: begin
            if (pwr_cnt == PWRUP_LAST) begin
              state     <= S_SETUP;
              src_user  <= 1'b0;
              cfg_index <= '0;
              i2c_data  <= {SLAVE_ADDR, table_word(4'd0)};
              w_r       <= bus.MUTE;
              setup_cnt <= 1'b0;
            end else begin
              pwr_cnt <= pwr_cnt + 1'b1;
            end
          end
          // Two ticks with GO low let the engine drop END before the transfer.
          S_SETUP: begin
            if (setup_cnt) begin
              state   <= S_XFER;
              go      <= 1'b1;
              tmo_cnt <= '0;
            end else begin
              setup_cnt <= 1'b1;
            end
          end
          S_XFER: begin
            if (bus.END) begin
              state <= S_CHECK;
              go    <= 1'b0;
              fail  <= bus.ACK;
            end else if (tmo_cnt == TMO_LAST) begin
              state <= S_CHECK;
              go    <= 1'b0;
              fail  <= 1'b1;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
          S_CHECK: begin
            if (fail && (retry < RETRY_MAX)) begin
              retry     <= retry + 1'b1;
              state     <= S_SETUP;
              w_r       <= bus.MUTE;
              setup_cnt <= 1'b0;
            end else begin
              retry <= '0;
              if (src_user) begin
                usr_done <= 1'b1;
                usr_err  <= fail;
                state    <= S_IDLE;
              end else begin
                cfg_err <= cfg_err | fail;
                if (cfg_index == IDX_LAST) begin
                  cfg_done <= 1'b1;
                  state    <= S_IDLE;
                end else begin
                  cfg_index <= cfg_index + 4'd1;
                  i2c_data  <= {SLAVE_ADDR, table_word(cfg_index + 4'd1)};
                  w_r       <= bus.MUTE;
                  setup_cnt <= 1'b0;
                  state     <= S_SETUP;
                end
              end
            end
          end
          S_IDLE: begin
            if (bus.USR_REQ) begin
              src_user  <= 1'b1;
              i2c_data  <= {SLAVE_ADDR, bus.USR_WORD};
              w_r       <= bus.MUTE;
              setup_cnt <= 1'b0;
              state     <= S_SETUP;
            end
          end
          default: state <= S_PWRUP;
        endcase
      end
    end
  end

  assign bus.I2C_CTRL_CLK = ctrl_clk;
  assign bus.I2C_DATA     = i2c_data;
  assign bus.GO           = go;
  assign bus.W_R          = w_r;
  assign bus.USR_DONE     = usr_done;
  assign bus.USR_ERR      = usr_err;
  assign bus.CFG_DONE     = cfg_done;
  assign bus.CFG_ERR      = cfg_err;
  assign bus.CFG_INDEX    = cfg_index;
  assign bus.BUSY         = (state != S_IDLE);

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Bench for i2c_cfg_sequencer: a behavioural I2C engine with programmable NACK /
// stuck-END behaviour logs every transfer; tasks compare logs to the table rules.
module tb_i2c_cfg_sequencer;
  localparam int CLK_DIV     = 2;
  localparam int NUM_REGS    = 11;
  localparam int MAX_RETRY   = 3;
  localparam int PWRUP_TICKS = 16;
  localparam int XFER_TMO    = 64;
  localparam int TICK_CYC    = 2 * CLK_DIV;
  localparam int LIMIT       = 20000;

  logic CLOCK = 1'b0;
  logic RESET = 1'b0;

  i2c_cfg_sequencer_if bus ();

  i2c_cfg_sequencer #(
    .CLK_DIV(CLK_DIV), .SLAVE_ADDR(8'h34), .NUM_REGS(NUM_REGS), .MAX_RETRY(MAX_RETRY),
    .PWRUP_TICKS(PWRUP_TICKS), .XFER_TMO(XFER_TMO)
  ) dut (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .bus(bus)
  );

  always #5 CLOCK = ~CLOCK;

  int checks = 0;
  int errors = 0;

  logic [15:0] ref_table [NUM_REGS] = '{16'h1E00, 16'h001A, 16'h021A, 16'h047B, 16'h067B,
                                         16'h08F8, 16'h0A06, 16'h0C00, 16'h0E01, 16'h1002, 16'h1201};

  // Engine behaviour knobs, written only by the stimulus tasks.
  logic [15:0] nack_word  = 16'hFFFF;
  int          nack_n     = 0;
  logic [15:0] stuck_word = 16'hFFFF;
  bit          stuck_en   = 1'b0;
  int          epoch      = 0;

  // Transfer logs, written only by the engine model and GO monitor.
  logic [23:0] xfer_q [$];
  logic        wr_q   [$];
  int          go_q   [$];

  int eng_cnt, eng_lat, match_cnt;
  int seen_epoch = -1;
  bit active, cur_stuck, cur_nack;

  // Engine: END low while GO is low, rises a random number of engine clocks after
  // GO unless the word is configured stuck; ACK reports a NACK for chosen attempts.
  always @(posedge bus.I2C_CTRL_CLK or negedge RESET) begin
    if (!RESET) begin
      eng_cnt = 0;
      active  = 1'b0;
      bus.END <= 1'b1;
      bus.ACK <= 1'b0;
    end else if (!bus.GO) begin
      eng_cnt = 0;
      active  = 1'b0;
      bus.END <= 1'b0;
      bus.ACK <= 1'b0;
    end else if (!active) begin
      active  = 1'b1;
      eng_cnt = 0;
      eng_lat = $urandom_range(3, 33);
      xfer_q.push_back(bus.I2C_DATA);
      wr_q.push_back(bus.W_R);
      if (seen_epoch != epoch) begin
        seen_epoch = epoch;
        match_cnt  = 0;
      end
      cur_stuck = stuck_en && (bus.I2C_DATA[15:0] == stuck_word);
      cur_nack  = 1'b0;
      if (bus.I2C_DATA[15:0] == nack_word) begin
        cur_nack  = (match_cnt < nack_n);
        match_cnt = match_cnt + 1;
      end
    end else if (!cur_stuck) begin
      if (eng_cnt >= eng_lat) begin
        bus.END <= 1'b1;
        bus.ACK <= cur_nack;
      end else begin
        eng_cnt = eng_cnt + 1;
      end
    end
  end

  int go_run = 0;
  always @(negedge CLOCK) begin
    if (!RESET) go_run = 0;
    else if (bus.GO) go_run = go_run + 1;
    else if (go_run > 0) begin
      go_q.push_back(go_run);
      go_run = 0;
    end
  end

  task automatic enter_reset();
    RESET = 1'b0;
    #1;
  endtask

  task automatic leave_reset();
    repeat (3) @(posedge CLOCK);
    @(negedge CLOCK);
    RESET = 1'b1;
  endtask

  task automatic wait_cfg_done(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < LIMIT; i++) begin
      @(posedge CLOCK); #1;
      if (bus.CFG_DONE) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s timeout: CFG_DONE=%0b, wanted 1 within %0d cycles", name, bus.CFG_DONE, LIMIT);
    end
  endtask

  task automatic wait_usr_done(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < LIMIT; i++) begin
      @(posedge CLOCK); #1;
      if (bus.USR_DONE) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s timeout: USR_DONE=%0b, wanted 1 within %0d cycles", name, bus.USR_DONE, LIMIT);
    end
  endtask

  // Full init pass from reset; expected transfer list built from the retry rules.
  task automatic run_init(input string name, input int n_idx, input int n_cnt,
                          input int s_idx, input logic mute);
    logic [23:0] exp_q [$];
    bit          exp_err = 1'b0;
    int          base, gbase, att, got;
    bit          fail_e, wr_bad;
    epoch++;
    nack_word  = (n_idx >= 0) ? ref_table[n_idx] : 16'hFFFF;
    nack_n     = (n_idx >= 0) ? n_cnt : 0;
    stuck_en   = (s_idx >= 0);
    stuck_word = (s_idx >= 0) ? ref_table[s_idx] : 16'hFFFF;
    bus.MUTE    = mute;
    bus.USR_REQ = 1'b0;
    enter_reset();
    base  = xfer_q.size();
    gbase = go_q.size();
    for (int i = 0; i < NUM_REGS; i++) begin
      att = 1; fail_e = 1'b0;
      if (i == s_idx) begin
        att = MAX_RETRY + 1; fail_e = 1'b1;
      end else if (i == n_idx) begin
        att = ((n_cnt > MAX_RETRY) ? MAX_RETRY : n_cnt) + 1;
        fail_e = (n_cnt > MAX_RETRY);
      end
      repeat (att) exp_q.push_back({8'h34, ref_table[i]});
      exp_err |= fail_e;
    end
    leave_reset();
    wait_cfg_done(name);

    got = xfer_q.size() - base;
    checks++;
    if (got !== exp_q.size()) begin
      errors++;
      $display("FAIL %s count: issued %0d transfers, expected %0d", name, got, exp_q.size());
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (k >= got || xfer_q[base+k] !== exp_q[k]) begin
        errors++;
        $display("FAIL %s xfer[%0d]: got %06h, expected %06h", name, k,
                 (k < got) ? xfer_q[base+k] : 24'h0, exp_q[k]);
      end
    end
    wr_bad = 1'b0;
    for (int k = 0; k < got; k++) if (wr_q[base+k] !== mute) wr_bad = 1'b1;
    checks++;
    if (wr_bad) begin
      errors++;
      $display("FAIL %s w_r: a transfer had W_R != MUTE, expected %0b", name, mute);
    end
    if (s_idx >= 0) begin
      for (int k = 0; k < exp_q.size() && k < got; k++) begin
        if (exp_q[k][15:0] == stuck_word) begin
          checks++;
          if ((gbase + k) >= go_q.size() || go_q[gbase+k] !== XFER_TMO * TICK_CYC) begin
            errors++;
            $display("FAIL %s timeout_len[%0d]: GO high %0d cycles, expected %0d", name, k,
                     ((gbase + k) < go_q.size()) ? go_q[gbase+k] : -1, XFER_TMO * TICK_CYC);
          end
        end
      end
    end
    checks++;
    if (bus.CFG_ERR !== exp_err) begin
      errors++;
      $display("FAIL %s cfg_err: got %0b, expected %0b", name, bus.CFG_ERR, exp_err);
    end
    checks++;
    if (bus.BUSY !== 1'b0 || bus.GO !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: BUSY=%0b GO=%0b, expected 0 0", name, bus.BUSY, bus.GO);
    end
    checks++;
    if (bus.CFG_INDEX !== 4'(NUM_REGS - 1)) begin
      errors++;
      $display("FAIL %s cfg_index: got %0d, expected %0d", name, bus.CFG_INDEX, NUM_REGS - 1);
    end
  endtask

  task automatic test_reset();
    bus.MUTE = 1'b0; bus.USR_REQ = 1'b0; bus.USR_WORD = 16'h0;
    enter_reset();
    leave_reset();
    repeat (37) @(posedge CLOCK);
    #3;
    RESET = 1'b0;
    #1;
    checks++;
    if ({bus.I2C_CTRL_CLK, bus.GO, bus.W_R, bus.USR_DONE, bus.USR_ERR, bus.CFG_DONE, bus.CFG_ERR} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: clk/go/wr/udone/uerr/cdone/cerr=%07b, expected 0000000",
               {bus.I2C_CTRL_CLK, bus.GO, bus.W_R, bus.USR_DONE, bus.USR_ERR, bus.CFG_DONE, bus.CFG_ERR});
    end
    checks++;
    if (bus.I2C_DATA !== 24'h0) begin
      errors++;
      $display("FAIL reset_data: got %06h, expected 000000", bus.I2C_DATA);
    end
    checks++;
    if (bus.CFG_INDEX !== 4'd0) begin
      errors++;
      $display("FAIL reset_index: got %0d, expected 0", bus.CFG_INDEX);
    end
    checks++;
    if (bus.BUSY !== 1'b1) begin
      errors++;
      $display("FAIL reset_busy: got %0b, expected 1", bus.BUSY);
    end
  endtask

  task automatic test_init_clean();
    run_init("t1_clean", -1, 0, -1, 1'b0);
  endtask

  task automatic test_nack_retry();
    run_init("t2_nack_twice", 3, 2, -1, 1'b0);
  endtask

  task automatic test_nack_exhaust();
    run_init("t3_nack_always", 5, 1000, -1, 1'b0);
  endtask

  task automatic test_random_nack();
    for (int r = 0; r < 2; r++)
      run_init("rand_nack", $urandom_range(0, NUM_REGS - 1), $urandom_range(1, 5), -1, 1'($urandom_range(0, 1)));
  endtask

  task automatic test_timeout_mute();
    run_init("t5_stuck_end", $urandom_range(0, NUM_REGS - 1) == 0 ? 0 : -1, 0, $urandom_range(0, NUM_REGS - 1), 1'b1);
  endtask

  task automatic test_user_during_init();
    int base, got;
    epoch++;
    nack_n = 0; stuck_en = 1'b0; bus.MUTE = 1'b0;
    enter_reset();
    base = xfer_q.size();
    bus.USR_WORD = 16'h0C10;
    bus.USR_REQ  = 1'b1;
    leave_reset();
    wait_usr_done("t4_user");
    got = xfer_q.size() - base;
    checks++;
    if (bus.CFG_DONE !== 1'b1 || got !== NUM_REGS + 1) begin
      errors++;
      $display("FAIL t4_order: CFG_DONE=%0b transfers=%0d, expected 1 and %0d", bus.CFG_DONE, got, NUM_REGS + 1);
    end
    checks++;
    if (got >= NUM_REGS + 1 && (xfer_q[base+NUM_REGS] !== 24'h340C10 || xfer_q[base+NUM_REGS-1] !== 24'h341201)) begin
      errors++;
      $display("FAIL t4_words: last two %06h %06h, expected 341201 340C10",
               xfer_q[base+NUM_REGS-1], xfer_q[base+NUM_REGS]);
    end
    checks++;
    if (bus.USR_ERR !== 1'b0) begin
      errors++;
      $display("FAIL t4_usr_err: got %0b, expected 0", bus.USR_ERR);
    end
    bus.USR_REQ = 1'b0;
    @(posedge CLOCK); #1;
    checks++;
    if (bus.USR_DONE !== 1'b0) begin
      errors++;
      $display("FAIL t4_pulse: USR_DONE=%0b one cycle later, expected 0", bus.USR_DONE);
    end
    repeat (10 * TICK_CYC) @(posedge CLOCK);
    #1;
    checks++;
    if (xfer_q.size() - base !== NUM_REGS + 1 || bus.BUSY !== 1'b0) begin
      errors++;
      $display("FAIL t4_quiet: transfers=%0d BUSY=%0b, expected %0d and 0", xfer_q.size() - base, bus.BUSY, NUM_REGS + 1);
    end
  endtask

  // Runtime writes issued back to back (request re-raised in the USR_DONE cycle).
  task automatic test_back_to_back();
    logic [15:0] word;
    logic        mute;
    int          n, base, got, att;
    for (int r = 0; r < 5; r++) begin
      word = 16'($urandom);
      mute = 1'($urandom_range(0, 1));
      n    = (r == 4) ? 4 : $urandom_range(0, 5);
      epoch++;
      nack_word = word; nack_n = n; stuck_en = 1'b0;
      bus.MUTE = mute;
      base = xfer_q.size();
      bus.USR_WORD = word;
      bus.USR_REQ  = 1'b1;
      wait_usr_done("b2b");
      bus.USR_REQ = 1'b0;
      got = xfer_q.size() - base;
      att = ((n > MAX_RETRY) ? MAX_RETRY : n) + 1;
      checks++;
      if (got !== att) begin
        errors++;
        $display("FAIL b2b_count[%0d]: %0d transfers of %04h, expected %0d", r, got, word, att);
      end
      for (int k = 0; k < got; k++) begin
        checks++;
        if (xfer_q[base+k] !== {8'h34, word} || wr_q[base+k] !== mute) begin
          errors++;
          $display("FAIL b2b_word[%0d.%0d]: data %06h w_r %0b, expected %06h w_r %0b",
                   r, k, xfer_q[base+k], wr_q[base+k], {8'h34, word}, mute);
        end
      end
      checks++;
      if (bus.USR_ERR !== (n > MAX_RETRY)) begin
        errors++;
        $display("FAIL b2b_err[%0d]: USR_ERR=%0b, expected %0b (nacks=%0d)", r, bus.USR_ERR, n > MAX_RETRY, n);
      end
    end
  endtask

  task automatic test_reset_mid_xfer();
    int  base, base2, cyc;
    bit  ok;
    epoch++;
    nack_n = 0; stuck_en = 1'b0; bus.MUTE = 1'b0; bus.USR_REQ = 1'b0;
    enter_reset();
    base = xfer_q.size();
    leave_reset();
    ok = 1'b0;
    for (int i = 0; i < LIMIT; i++) begin
      @(posedge CLOCK); #1;
      if (xfer_q.size() - base >= 5 && bus.GO) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || xfer_q[base+4] !== 24'h34067B) begin
      errors++;
      $display("FAIL t6_reach: reached=%0b idx4 word %06h, expected 1 and 34067B", ok,
               (xfer_q.size() - base >= 5) ? xfer_q[base+4] : 24'h0);
    end
    #2;
    RESET = 1'b0;
    #1;
    checks++;
    if (bus.GO !== 1'b0 || bus.I2C_DATA !== 24'h0 || bus.BUSY !== 1'b1 || bus.CFG_INDEX !== 4'd0 ||
        bus.W_R !== 1'b0 || bus.I2C_CTRL_CLK !== 1'b0 || bus.CFG_DONE !== 1'b0) begin
      errors++;
      $display("FAIL t6_abort: GO=%0b DATA=%06h BUSY=%0b IDX=%0d W_R=%0b CLK=%0b DONE=%0b, expected 0 000000 1 0 0 0 0",
               bus.GO, bus.I2C_DATA, bus.BUSY, bus.CFG_INDEX, bus.W_R, bus.I2C_CTRL_CLK, bus.CFG_DONE);
    end
    base2 = xfer_q.size();
    leave_reset();
    cyc = 0; ok = 1'b0;
    for (int i = 0; i < LIMIT; i++) begin
      @(posedge CLOCK); #1;
      cyc++;
      if (bus.GO) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || cyc < PWRUP_TICKS * TICK_CYC || cyc > (PWRUP_TICKS + 3) * TICK_CYC) begin
      errors++;
      $display("FAIL t6_pwrup: first GO after %0d cycles, expected %0d..%0d", cyc,
               PWRUP_TICKS * TICK_CYC, (PWRUP_TICKS + 3) * TICK_CYC);
    end
    repeat (2 * TICK_CYC) @(posedge CLOCK);
    #1;
    checks++;
    if (xfer_q.size() <= base2 || xfer_q[base2] !== 24'h341E00) begin
      errors++;
      $display("FAIL t6_restart: first word %06h, expected 341E00",
               (xfer_q.size() > base2) ? xfer_q[base2] : 24'h0);
    end
  endtask

  initial begin
    bus.MUTE = 1'b0;
    bus.USR_REQ = 1'b0;
    bus.USR_WORD = 16'h0;
    test_reset();
    test_init_clean();
    test_nack_retry();
    test_nack_exhaust();
    test_random_nack();
    test_timeout_mute();
    test_user_during_init();
    test_back_to_back();
    test_reset_mid_xfer();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
